// File: rtl/slfifo_burst_scheduler.sv
// ---------------------------------------------------------------------------
// slfifo_burst_scheduler
//
// Shares the FX3 slave-FIFO write bus between CHN_NUM upstream FWFT channel
// FIFOs. A round-robin arbiter picks a ready channel. The block then streams
// one fixed burst of BURST_LEN words onto the bus and holds off while the FX3
// reports full. After the burst it idles for GAP_CYC cycles, and the next
// arbitration starts at the channel after the one just served.
//
// Optional feature macro: SLFIFO_PKTEND_EN
//   defined     : pktend_n pulses low together with the last word of a burst
//   not defined : pktend_n is tied high
//
// Ports
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               synchronous reset, active low
//   chn_rdy    in   CHN_NUM         channel i holds >= BURST_LEN words
//   chn_data   in   CHN_NUM*DATA_W  FWFT head word of channel i at [i*DATA_W +: DATA_W]
//   chn_rd     out  CHN_NUM         pop strobe, one-hot or zero (combinational)
//   usb_full_n in   1               FX3 full flag, low = stop writing
//   usb_dq     out  DATA_W          registered write data
//   slwr_n     out  1               registered write strobe, active low
//   pktend_n   out  1               registered packet end, active low
//   sladdr     out  ADDR_W          socket address = granted channel index
//   busy       out  1               high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module slfifo_burst_scheduler #(
   parameter int CHN_NUM   = 4,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 256,
   parameter int CNT_W     = 8,
   parameter int ADDR_W    = 2,
   parameter int GAP_CYC   = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHN_NUM-1:0]        chn_rdy,
   input  logic [CHN_NUM*DATA_W-1:0] chn_data,
   output logic [CHN_NUM-1:0]        chn_rd,
   input  logic                      usb_full_n,
   output logic [DATA_W-1:0]         usb_dq,
   output logic                      slwr_n,
   output logic                      pktend_n,
   output logic [ADDR_W-1:0]         sladdr,
   output logic                      busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARB   = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] sel;
   logic [CNT_W-1:0]  word_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic              grant_found;
   logic [ADDR_W-1:0] grant_idx;
   logic [ADDR_W-1:0] cand_idx;
   int                cand;
   logic              pop;
   logic              last_pop;

   // Round-robin search: scan CHN_NUM candidates starting at ptr and wrap
   // at CHN_NUM-1. The first ready channel found wins. The modulo is done by
   // a subtraction, so CHN_NUM does not have to be a power of two.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < CHN_NUM; i++) begin
         cand = int'(ptr) + i;
         if (cand >= CHN_NUM) begin
            cand = cand - CHN_NUM;
         end
         cand_idx = ADDR_W'(cand);
         if (!grant_found && chn_rdy[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // A pop is issued directly from the full flag. This lets the FX3 pause
   // the transfer within the same cycle without a skid buffer.
   assign pop      = (state == S_BURST) && usb_full_n;
   assign last_pop = pop && (word_cnt == CNT_W'(BURST_LEN - 1));
   assign busy     = (state != S_IDLE);

   always_comb begin
      chn_rd = '0;
      if (pop) begin
         chn_rd[sel] = 1'b1;
      end
   end

   // Control FSM. sel and sladdr are updated only in ARB. A channel that
   // drops ready mid-burst therefore still gets popped until the burst ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= '0;
         sel      <= '0;
         sladdr   <= '0;
         word_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|chn_rdy) begin
                  state <= S_ARB;
               end
            end
            S_ARB: begin
               if (grant_found) begin
                  sel      <= grant_idx;
                  sladdr   <= grant_idx;
                  ptr      <= (grant_idx == ADDR_W'(CHN_NUM - 1)) ? '0
                                                                 : grant_idx + ADDR_W'(1);
                  word_cnt <= '0;
                  state    <= S_BURST;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_BURST: begin
               if (last_pop) begin
                  word_cnt <= '0;
                  gap_cnt  <= '0;
                  state    <= S_GAP;
               end else if (pop) begin
                  word_cnt <= word_cnt + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output register stage. The FWFT head word popped in cycle N is
   // presented with slwr_n low in cycle N+1. The data holds while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         usb_dq <= '0;
         slwr_n <= 1'b1;
      end else if (pop) begin
         usb_dq <= chn_data[sel*DATA_W +: DATA_W];
         slwr_n <= 1'b0;
      end else begin
         slwr_n <= 1'b1;
      end
   end

`ifdef SLFIFO_PKTEND_EN
   // pktend_n is registered from the same pop as slwr_n, so it lines up
   // with the last word of the burst.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pktend_n <= 1'b1;
      end else begin
         pktend_n <= ~last_pop;
      end
   end
`else
   assign pktend_n = 1'b1;
`endif

endmodule

// File: tb/tb_slfifo_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slfifo_burst_scheduler
//
// Directed bench for slfifo_burst_scheduler. Each channel is modelled as an
// FWFT FIFO whose head word is {channel, sequence}. Each stimulus step pushes
// the words the bus should carry into a scoreboard queue. A monitor on the
// falling edge pops one entry for every slwr_n-low cycle and compares data,
// address, pktend_n and the slwr_n-high run that precedes the word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slfifo_burst_scheduler;

   localparam int CHN_NUM   = 4;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 256;
   localparam int CNT_W     = 8;
   localparam int ADDR_W    = 2;
   localparam int GAP_CYC   = 3;
   // slwr_n-high cycles between back-to-back bursts: GAP + IDLE + ARB,
   // seen one cycle later through the output register
   localparam int B2B_GAP   = GAP_CYC + 2;

   logic                      clk;
   logic                      rst_n;
   logic [CHN_NUM-1:0]        chn_rdy;
   logic [CHN_NUM*DATA_W-1:0] chn_data;
   logic [CHN_NUM-1:0]        chn_rd;
   logic                      usb_full_n;
   logic [DATA_W-1:0]         usb_dq;
   logic                      slwr_n;
   logic                      pktend_n;
   logic [ADDR_W-1:0]         sladdr;
   logic                      busy;

   typedef struct {
      int chan;
      int seq;
      bit last;
      int gap;
   } exp_t;

   exp_t sb[$];

   int vectors     = 0;
   int miscompares = 0;

   int loaded  [CHN_NUM] = '{default: 0};
   int popped  [CHN_NUM] = '{default: 0};
   int exp_seq [CHN_NUM] = '{default: 0};
   int total_pops        = 0;

   slfifo_burst_scheduler #(
      .CHN_NUM   (CHN_NUM),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W),
      .ADDR_W    (ADDR_W),
      .GAP_CYC   (GAP_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .chn_rdy    (chn_rdy),
      .chn_data   (chn_data),
      .chn_rd     (chn_rd),
      .usb_full_n (usb_full_n),
      .usb_dq     (usb_dq),
      .slwr_n     (slwr_n),
      .pktend_n   (pktend_n),
      .sladdr     (sladdr),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Channel FIFO model: the fill level is loaded - popped, and the head word
   // carries the channel number and the index of the next word.
   always_comb begin
      chn_rdy  = '0;
      chn_data = '0;
      for (int c = 0; c < CHN_NUM; c++) begin
         chn_rdy[c] = (loaded[c] - popped[c]) >= BURST_LEN;
         chn_data[c*DATA_W +: DATA_W] = {8'(c), 24'(popped[c])};
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < CHN_NUM; c++) begin
         if (chn_rd[c]) begin
            popped[c] <= popped[c] + 1;
         end
      end
      total_pops <= total_pops + ((chn_rd != '0) ? 1 : 0);
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Loads words into a channel FIFO.
   task automatic applyStimulus(input int chan, input int words);
      loaded[chan] = loaded[chan] + words;
   endtask

   // Queues one full burst. first_gap is the slwr_n-high run expected before
   // word 0 (-1 = don't care). pause_word gets pause_gap instead of 0.
   task automatic expectBurst(input int chan, input int first_gap, input int pause_word, input int pause_gap);
      exp_t e;
      for (int i = 0; i < BURST_LEN; i++) begin
         e.chan = chan;
         e.seq  = exp_seq[chan] + i;
         e.last = (i == BURST_LEN - 1);
         e.gap  = (i == 0) ? first_gap : ((i == pause_word) ? pause_gap : 0);
         sb.push_back(e);
      end
      exp_seq[chan] = exp_seq[chan] + BURST_LEN;
   endtask

   task automatic expectPartial(input int chan, input int words);
      exp_t e;
      for (int i = 0; i < words; i++) begin
         e.chan = chan;
         e.seq  = exp_seq[chan] + i;
         e.last = 1'b0;
         e.gap  = (i == 0) ? -1 : 0;
         sb.push_back(e);
      end
      exp_seq[chan] = exp_seq[chan] + words;
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_slwr_n",   64'(slwr_n),   64'd1);
      checkOutput("rst_pktend_n", 64'(pktend_n), 64'd1);
      checkOutput("rst_usb_dq",   64'(usb_dq),   64'd0);
      checkOutput("rst_sladdr",   64'(sladdr),   64'd0);
      checkOutput("rst_chn_rd",   64'(chn_rd),   64'd0);
      checkOutput("rst_busy",     64'(busy),     64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic waitIdle(input string name);
      for (int n = 0; n < 8000; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            return;
         end
      end
      timeoutFail(name);
      sb.delete();
   endtask

   task automatic waitPops(input int target, input string name);
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         if (total_pops >= target) begin
            return;
         end
      end
      timeoutFail(name);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      int   high_run;
      bit   pk_exp;
      high_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            high_run = 0;
         end else begin
            pk_exp = 1'b1;
            if (!slwr_n) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_write", 64'(usb_dq), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  checkOutput("usb_dq", 64'(usb_dq), 64'({8'(e.chan), 24'(e.seq)}));
                  checkOutput("sladdr", 64'(sladdr), 64'(e.chan));
                  if (e.gap >= 0) begin
                     checkOutput("slwr_gap", 64'(high_run), 64'(e.gap));
                  end
`ifdef SLFIFO_PKTEND_EN
                  pk_exp = !e.last;
`endif
               end
               high_run = 0;
            end else begin
               high_run++;
            end
            checkOutput("pktend_n", 64'(pktend_n), 64'(pk_exp));
            if (chn_rd != '0) begin
               checkOutput("chn_rd_onehot", 64'($onehot(chn_rd)), 64'd1);
               for (int c = 0; c < CHN_NUM; c++) begin
                  if (chn_rd[c]) begin
                     checkOutput("pop_nonempty", 64'((loaded[c] - popped[c]) > 0), 64'd1);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int start;
      rst_n      = 1'b0;
      usb_full_n = 1'b1;

      // Scenario A: all four channels ready, chn 0 holds two bursts
      resetDut();
      applyStimulus(0, 2*BURST_LEN);
      applyStimulus(1, BURST_LEN);
      applyStimulus(2, BURST_LEN);
      applyStimulus(3, BURST_LEN);
      expectBurst(0, -1,      -1, 0);
      expectBurst(1, B2B_GAP, -1, 0);
      expectBurst(2, B2B_GAP, -1, 0);
      expectBurst(3, B2B_GAP, -1, 0);
      expectBurst(0, B2B_GAP, -1, 0);
      waitIdle("scenA_done");

      // Scenario B: chn 2 absent, order 0,1,3,0 from a fresh pointer
      resetDut();
      applyStimulus(0, 2*BURST_LEN);
      applyStimulus(1, BURST_LEN);
      applyStimulus(3, BURST_LEN);
      expectBurst(0, -1,      -1, 0);
      expectBurst(1, B2B_GAP, -1, 0);
      expectBurst(3, B2B_GAP, -1, 0);
      expectBurst(0, B2B_GAP, -1, 0);
      waitIdle("scenB_done");

      // Scenario C: only chn 0 ready (pointer sits at 1, search must wrap),
      // FX3 full for 10 cycles at word 100 of the first burst
      start = total_pops;
      applyStimulus(0, 2*BURST_LEN);
      expectBurst(0, -1,      100, 10);
      expectBurst(0, B2B_GAP, -1,  0);
      waitPops(start + 100, "scenC_word100");
      usb_full_n = 1'b0;
      repeat (10) @(posedge clk);
      #1 usb_full_n = 1'b1;
      waitIdle("scenC_done");

      // Scenario D: reset at word 50 of a chn 1 burst (pointer then at 2);
      // afterwards chn 0 must win over chn 2
      start = total_pops;
      applyStimulus(1, BURST_LEN);
      expectPartial(1, 50);
      waitPops(start + 50, "scenD_word50");
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_slwr_n", 64'(slwr_n),    64'd1);
      checkOutput("abort_chn_rd", 64'(chn_rd),    64'd0);
      checkOutput("abort_busy",   64'(busy),      64'd0);
      checkOutput("abort_drain",  64'(sb.size()), 64'd0);
      #1 rst_n = 1'b1;
      applyStimulus(0, BURST_LEN);
      applyStimulus(2, BURST_LEN);
      expectBurst(0, -1,      -1, 0);
      expectBurst(2, B2B_GAP, -1, 0);
      waitIdle("scenD_done");

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
